// File: rtl/processor_pkg.sv
// Shared widths and the memory-stage FSM encoding for the 16-bit pipeline.
package processor_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/data_memory_component.sv
// Single-port synchronous data RAM, registered read, read-before-write on a shared edge.
module data_memory_component
  import processor_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_BITS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_cycle.sv
// Memory stage: one load/store per instruction with WAIT_STATES extra cycles,
// upstream stall while busy, registered writeback bundle and forwarding value.
module memory_cycle
  import processor_pkg::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     aluout,
  input  logic [WORD_W-1:0]     bout,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  regwrite,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic                  memtoreg,
  output logic                  stall,
  output logic [WORD_W-1:0]     memout,
  output logic [WORD_W-1:0]     aluout_wb,
  output logic [REG_ADDR_W-1:0] rdout,
  output logic                  regwriteout,
  output logic                  memtoregout,
  output logic [WORD_W-1:0]     forwarded_aluout,
  output logic                  dbg_state,
  output logic [1:0]            dbg_cnt
);

  localparam logic [1:0] WS = WAIT_STATES[1:0];

  mem_state_t            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WORD_W-1:0]     aluout_wb_q, aluout_wb_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic                  load_q, load_d;
  logic [ADDR_BITS-1:0]  raddr_q, raddr_d;

  logic                  req;
  logic                  done;
  logic                  advance;
  logic [ADDR_BITS-1:0]  addr_now;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic                  ram_we;
  logic [WORD_W-1:0]     ram_rdata;
  logic                  unused_addr_bits;

  assign req      = memread | memwrite;
  assign done     = (cnt_q == WS);
  assign stall    = req & ~done;
  assign advance  = ~stall;
  assign addr_now = aluout[ADDR_BITS:1];
  assign unused_addr_bits = ^{aluout[0], aluout[WORD_W-1:ADDR_BITS+1]};

  // While stalled the RAM keeps re-reading the last completed address, so its
  // registered output (and thus memout) holds; nothing is written then.
  assign ram_addr = advance ? addr_now : raddr_q;
  assign ram_we   = memwrite & advance;

  data_memory_component #(.ADDR_BITS(ADDR_BITS)) u_dmem (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(bout),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aluout_wb_d = aluout_wb_q;
    rd_d        = rd_q;
    regwrite_d  = regwrite_q;
    memtoreg_d  = memtoreg_q;
    load_d      = load_q;
    raddr_d     = raddr_q;

    case (state_q)
      IDLE: begin
        if (stall) begin
          state_d = WAIT;
          cnt_d   = 2'd1;
        end
      end
      WAIT: begin
        if (stall) begin
          cnt_d = 2'(cnt_q + 2'd1);
        end else begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    if (stall) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else begin
      aluout_wb_d = aluout;
      rd_d        = rd;
      regwrite_d  = regwrite;
      memtoreg_d  = memtoreg;
      load_d      = memread & ~memwrite;
      raddr_d     = addr_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      aluout_wb_q <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      load_q      <= 1'b0;
      raddr_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aluout_wb_q <= aluout_wb_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      load_q      <= load_d;
      raddr_q     <= raddr_d;
    end
  end

  // Stores and non-memory instructions leave load_q clear, forcing memout to 0.
  assign memout           = load_q ? ram_rdata : '0;
  assign aluout_wb        = aluout_wb_q;
  assign rdout            = rd_q;
  assign regwriteout      = regwrite_q;
  assign memtoregout      = memtoreg_q;
  assign forwarded_aluout = memtoreg_q ? memout : aluout_wb_q;
  assign dbg_state        = state_q;
  assign dbg_cnt          = cnt_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: three instances (WAIT_STATES 1, 3, 0) with a shared
// reference memory model and an expected-bundle queue.
module tb_memory_cycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] aluout_a [3];
  logic [15:0] bout_a [3];
  logic [3:0]  rd_a [3];
  logic        regwrite_a [3];
  logic        memread_a [3];
  logic        memwrite_a [3];
  logic        memtoreg_a [3];

  wire         stall_a [3];
  wire  [15:0] memout_a [3];
  wire  [15:0] aluout_wb_a [3];
  wire  [3:0]  rdout_a [3];
  wire         regwriteout_a [3];
  wire         memtoregout_a [3];
  wire  [15:0] fwd_a [3];
  wire         dbg_state_a [3];
  wire  [1:0]  dbg_cnt_a [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    memory_cycle #(
      .ADDR_BITS  (10),
      .WAIT_STATES(k == 0 ? 1 : (k == 1 ? 3 : 0))
    ) dut (
      .clk             (clk),
      .rst             (rst),
      .aluout          (aluout_a[k]),
      .bout            (bout_a[k]),
      .rd              (rd_a[k]),
      .regwrite        (regwrite_a[k]),
      .memread         (memread_a[k]),
      .memwrite        (memwrite_a[k]),
      .memtoreg        (memtoreg_a[k]),
      .stall           (stall_a[k]),
      .memout          (memout_a[k]),
      .aluout_wb       (aluout_wb_a[k]),
      .rdout           (rdout_a[k]),
      .regwriteout     (regwriteout_a[k]),
      .memtoregout     (memtoregout_a[k]),
      .forwarded_aluout(fwd_a[k]),
      .dbg_state       (dbg_state_a[k]),
      .dbg_cnt         (dbg_cnt_a[k])
    );

    logic        sv_stall;
    logic [39:0] snap;
    wire  [39:0] in_now = {aluout_a[k], bout_a[k], rd_a[k], regwrite_a[k],
                           memread_a[k], memwrite_a[k], memtoreg_a[k]};

    // Upstream contract: inputs stay put across any edge where stall was high.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        sv_stall <= 1'b0;
      end else begin
        if (sv_stall) begin
          assert (in_now == snap) else $error("inst %0d input changed during stall", k);
        end
        sv_stall <= stall_a[k];
        snap     <= in_now;
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [37:0] exp_q [$];
  logic [15:0] ref_mem [3][1024];
  bit          ref_ok  [3][1024];
  logic [15:0] last_alu [3];

  function automatic int ws_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input int k, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] r, input logic rw, input logic mr,
                       input logic mw, input logic m2r);
    aluout_a[k]   = a;
    bout_a[k]     = b;
    rd_a[k]       = r;
    regwrite_a[k] = rw;
    memread_a[k]  = mr;
    memwrite_a[k] = mw;
    memtoreg_a[k] = m2r;
  endtask

  // Called just after a posedge; returns just after the completing edge.
  task automatic run_instr(input int k, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] r, input logic rw, input logic mr,
                           input logic mw, input logic m2r);
    logic [37:0] exp, got;
    logic [15:0] mo;
    logic [9:0]  w;
    int          n;
    bit          done;
    w  = a[10:1];
    mo = (mr && !mw) ? ref_mem[k][w] : 16'h0000;
    if (mw) begin
      ref_mem[k][w] = b;
      ref_ok[k][w]  = 1'b1;
    end
    exp = {mo, a, r, rw, m2r};
    exp_q.push_back(exp);
    drive(k, a, b, r, rw, mr, mw, m2r);
    n    = 0;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (!stall_a[k]) begin
        done = 1'b1;
      end else begin
        n++;
        @(posedge clk);
        #1;
        check("bubble_regwrite", {63'd0, regwriteout_a[k]}, 64'd0);
        check("bubble_memtoreg", {63'd0, memtoregout_a[k]}, 64'd0);
        check("bubble_hold_alu", {48'd0, aluout_wb_a[k]}, {48'd0, last_alu[k]});
      end
    end
    check("stall_timeout", {63'd0, done}, 64'd1);
    check("stall_cycles", 64'(n), 64'((mr | mw) ? ws_of(k) : 0));
    @(posedge clk);
    #1;
    got = {memout_a[k], aluout_wb_a[k], rdout_a[k], regwriteout_a[k], memtoregout_a[k]};
    check("wb_bundle", {26'd0, got}, {26'd0, exp_q.pop_front()});
    check("forwarded", {48'd0, fwd_a[k]}, {48'd0, (m2r ? mo : a)});
    last_alu[k] = a;
    drive(k, a, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outs(input int k, input string tag);
    check(tag, {9'd0, memout_a[k], aluout_wb_a[k], rdout_a[k], regwriteout_a[k],
                memtoregout_a[k], fwd_a[k]}, 64'd0);
    check({tag, "_fsm"}, {61'd0, dbg_state_a[k], dbg_cnt_a[k]}, 64'd0);
  endtask

  task automatic random_run(input int k, input int count);
    logic [15:0] a, b;
    logic [3:0]  wsel;
    int          op;
    for (int i = 0; i < count; i++) begin
      op   = $urandom_range(0, 2);
      wsel = 4'($urandom_range(0, 15));
      a    = {5'($urandom_range(0, 31)), 6'd0, wsel, 1'($urandom_range(0, 1))};
      b    = 16'($urandom_range(0, 65535));
      if (op == 2 && !ref_ok[k][{6'd0, wsel}]) op = 1;
      run_instr(k, a, b, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                op == 2, op == 1, op == 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      drive(k, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      last_alu[k] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_reset_outs(k, "reset_values");
      check("reset_stall", {63'd0, stall_a[k]}, 64'd0);
    end
    rst = 1'b0;

    // Reset mid-WAIT aborts a store; the earlier store survives.
    run_instr(0, 16'h0040, 16'h1111, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(0, 16'h0040, 16'h2222, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("abort_pre_stall", {63'd0, stall_a[0]}, 64'd1);
    @(posedge clk);
    #1;
    check("abort_in_wait", {61'd0, dbg_state_a[0], dbg_cnt_a[0]}, 64'd5);
    rst = 1'b1;
    #1;
    check_reset_outs(0, "abort_reset_outs");
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) last_alu[k] = 16'h0000;
    run_instr(0, 16'h0040, 16'h0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);

    // WAIT_STATES=1 directed cases.
    run_instr(0, 16'h1234, 16'h0000, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_instr(0, 16'h0010, 16'hBEEF, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(0, 16'h0010, 16'h0000, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    run_instr(0, 16'h0801, 16'h00AA, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(0, 16'h0000, 16'h0000, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    run_instr(0, 16'h0020, 16'h5555, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    run_instr(0, 16'h0020, 16'h0000, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    random_run(0, 25);

    // WAIT_STATES=3: three stall cycles and three bubbles per access.
    run_instr(1, 16'h0100, 16'hCAFE, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(1, 16'h0100, 16'h0000, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    run_instr(1, 16'h4321, 16'h0000, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    random_run(1, 20);

    // WAIT_STATES=0: back-to-back store then load of the same word.
    run_instr(2, 16'h0006, 16'hA5A5, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr(2, 16'h0007, 16'h0000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    random_run(2, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
